jtag_tap: RTL and testbench



---
 rtl/jtag_pkg.sv | 45 ++++
 rtl/jtag_tap_fsm.sv | 62 ++++++
 rtl/jtag_tap.sv | 171 +++++++++++++++++
 tb/tb_jtag_tap.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared constants and types for the JTAG TAP: IR codes, TAP state encoding,
// data-register select and the DMI request-word width derivation.
package jtag_pkg;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DTMCS   = 5'h10;
  localparam logic [4:0] IR_DMI     = 5'h11;
  localparam logic [4:0] IR_BYPASS  = 5'h1f;
  localparam logic [4:0] IR_CAPTURE = 5'b00001;

  // Classic 1149.1 state encoding, so a logic analyser trace reads naturally.
  typedef enum logic [3:0] {
    TAP_EX2_DR = 4'h0,
    TAP_EX1_DR = 4'h1,
    TAP_SH_DR  = 4'h2,
    TAP_PAU_DR = 4'h3,
    TAP_SEL_IR = 4'h4,
    TAP_UPD_DR = 4'h5,
    TAP_CAP_DR = 4'h6,
    TAP_SEL_DR = 4'h7,
    TAP_EX2_IR = 4'h8,
    TAP_EX1_IR = 4'h9,
    TAP_SH_IR  = 4'hA,
    TAP_PAU_IR = 4'hB,
    TAP_RTI    = 4'hC,
    TAP_UPD_IR = 4'hD,
    TAP_CAP_IR = 4'hE,
    TAP_TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_SEL_IDCODE,
    DR_SEL_DTMCS,
    DR_SEL_DMI,
    DR_SEL_BYPASS
  } dr_sel_e;

  function automatic int tap_req_bits(input int addr_bits, input int data_bits,
                                      input int op_bits);
    return addr_bits + data_bits + op_bits;
  endfunction

  localparam int TAP_REQ_BITS_DEFAULT = tap_req_bits(6, 32, 2);

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine driven by TMS; publishes the state and the
// per-state capture/shift/update strobes that act on the next TCK rising edge.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_tms,
  output tap_state_e o_state,
  output logic       o_tlr,
  output logic       o_capture_dr,
  output logic       o_shift_dr,
  output logic       o_update_dr,
  output logic       o_capture_ir,
  output logic       o_shift_ir,
  output logic       o_update_ir
);

  tap_state_e r_state;
  tap_state_e w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TAP_TLR:    w_next = i_tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: w_next = i_tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  w_next = i_tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: w_next = i_tms ? TAP_UPD_DR : TAP_PAU_DR;
      TAP_PAU_DR: w_next = i_tms ? TAP_EX2_DR : TAP_PAU_DR;
      TAP_EX2_DR: w_next = i_tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: w_next = i_tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  w_next = i_tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: w_next = i_tms ? TAP_UPD_IR : TAP_PAU_IR;
      TAP_PAU_IR: w_next = i_tms ? TAP_EX2_IR : TAP_PAU_IR;
      TAP_EX2_IR: w_next = i_tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: w_next = i_tms ? TAP_SEL_DR : TAP_RTI;
      default:    w_next = TAP_TLR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state <= TAP_TLR;
    end else begin
      r_state <= w_next;
    end
  end

  assign o_state      = r_state;
  assign o_tlr        = (r_state == TAP_TLR);
  assign o_capture_dr = (r_state == TAP_CAP_DR);
  assign o_shift_dr   = (r_state == TAP_SH_DR);
  assign o_update_dr  = (r_state == TAP_UPD_DR);
  assign o_capture_ir = (r_state == TAP_CAP_IR);
  assign o_shift_ir   = (r_state == TAP_SH_IR);
  assign o_update_ir  = (r_state == TAP_UPD_IR);

endmodule

// File: rtl/jtag_tap.sv
// JTAG TAP for the RISC-V debug transport: IR, IDCODE/DTMCS/DMI/BYPASS DR and DMI
// request generation. Define JTAG_DTMCS_WRITE_EN to make dtmcs.dmireset/dmihardreset writable.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int DMI_ADDR_BITS = 6,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int IR_BITS       = 5
) (
  input  logic                                                jtag_tck_i,
  input  logic                                                jtag_trst_i,
  input  logic                                                jtag_tms_i,
  input  logic                                                jtag_tdi_i,
  output logic                                                jtag_tdo_o,
  output logic                                                tap_req_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0]  tap_data_o,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0]  dm_resp_i,
  input  logic [31:0]                                         idcode_i,
  input  logic [31:0]                                         dtmcs_i,
  output logic                                                dmireset_o,
  output logic                                                dmihardreset_o
);

  localparam int TAP_REQ_BITS = tap_req_bits(DMI_ADDR_BITS, DMI_DATA_BITS, DMI_OP_BITS);
  localparam int DR_BITS      = (TAP_REQ_BITS > 32) ? TAP_REQ_BITS : 32;
  localparam int LEN_W        = $clog2(DR_BITS);

  tap_state_e w_state;
  logic       w_tlr;
  logic       w_capture_dr;
  logic       w_shift_dr;
  logic       w_update_dr;
  logic       w_capture_ir;
  logic       w_shift_ir;
  logic       w_update_ir;

  logic [IR_BITS-1:0]      r_ir;
  logic [IR_BITS-1:0]      r_ir_shift;
  logic [DR_BITS-1:0]      r_dr;
  logic [TAP_REQ_BITS-1:0] r_tap_data;
  logic                    r_tap_req;

  dr_sel_e            w_sel;
  logic [LEN_W-1:0]   w_dr_msb;
  logic [DR_BITS-1:0] w_dr_capture;
  logic [DR_BITS-1:0] w_dr_shifted;

  jtag_tap_fsm u_fsm (
    .i_clk        (jtag_tck_i),
    .i_srst       (jtag_trst_i),
    .i_tms        (jtag_tms_i),
    .o_state      (w_state),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_update_dr  (w_update_dr),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir)
  );

  always_comb begin
    w_sel = DR_SEL_BYPASS;
    if (r_ir == IR_BITS'(IR_IDCODE)) begin
      w_sel = DR_SEL_IDCODE;
    end else if (r_ir == IR_BITS'(IR_DTMCS)) begin
      w_sel = DR_SEL_DTMCS;
    end else if (r_ir == IR_BITS'(IR_DMI)) begin
      w_sel = DR_SEL_DMI;
    end
  end

  always_comb begin
    w_dr_msb     = '0;
    w_dr_capture = '0;
    case (w_sel)
      DR_SEL_IDCODE: begin
        w_dr_msb           = LEN_W'(31);
        w_dr_capture[31:0] = idcode_i;
      end
      DR_SEL_DTMCS: begin
        w_dr_msb           = LEN_W'(31);
        w_dr_capture[31:0] = dtmcs_i;
      end
      DR_SEL_DMI: begin
        w_dr_msb                        = LEN_W'(TAP_REQ_BITS - 1);
        w_dr_capture[TAP_REQ_BITS-1:0] = dm_resp_i;
      end
      default: begin
        w_dr_msb     = '0;
        w_dr_capture = '0;
      end
    endcase
  end

  // TDI enters at the top of the selected register; bits above it shift junk that is never used.
  genvar gi;
  generate
    for (gi = 0; gi < DR_BITS; gi++) begin : g_dr_shift
      if (gi == DR_BITS - 1) begin : g_top
        assign w_dr_shifted[gi] = jtag_tdi_i;
      end else begin : g_mid
        assign w_dr_shifted[gi] = (w_dr_msb == LEN_W'(gi)) ? jtag_tdi_i : r_dr[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge jtag_tck_i) begin
    if (jtag_trst_i) begin
      r_ir       <= IR_BITS'(IR_IDCODE);
      r_ir_shift <= '0;
      r_dr       <= '0;
      r_tap_data <= '0;
      r_tap_req  <= 1'b0;
    end else begin
      r_tap_req <= 1'b0;

      if (w_tlr) begin
        r_ir <= IR_BITS'(IR_IDCODE);
      end else if (w_update_ir) begin
        r_ir <= r_ir_shift;
      end

      if (w_capture_ir) begin
        r_ir_shift <= IR_BITS'(IR_CAPTURE);
      end else if (w_shift_ir) begin
        r_ir_shift <= {jtag_tdi_i, r_ir_shift[IR_BITS-1:1]};
      end

      if (w_capture_dr) begin
        r_dr <= w_dr_capture;
      end else if (w_shift_dr) begin
        r_dr <= w_dr_shifted;
      end

      // Every DMI update is forwarded; nop/read/write filtering happens downstream.
      if (w_update_dr && (w_sel == DR_SEL_DMI)) begin
        r_tap_data <= r_dr[TAP_REQ_BITS-1:0];
        r_tap_req  <= 1'b1;
      end
    end
  end

`ifdef JTAG_DTMCS_WRITE_EN
  logic r_dmireset;
  logic r_dmihardreset;

  always_ff @(posedge jtag_tck_i) begin
    if (jtag_trst_i) begin
      r_dmireset     <= 1'b0;
      r_dmihardreset <= 1'b0;
    end else begin
      r_dmireset     <= w_update_dr && (w_sel == DR_SEL_DTMCS) && r_dr[16];
      r_dmihardreset <= w_update_dr && (w_sel == DR_SEL_DTMCS) && r_dr[17];
    end
  end

  assign dmireset_o     = r_dmireset;
  assign dmihardreset_o = r_dmihardreset;
`else
  assign dmireset_o     = 1'b0;
  assign dmihardreset_o = 1'b0;
`endif

  assign jtag_tdo_o = (w_state == TAP_SH_DR) ? r_dr[0] :
                      (w_state == TAP_SH_IR) ? r_ir_shift[0] : 1'b0;
  assign tap_req_o  = r_tap_req;
  assign tap_data_o = r_tap_data;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: table of IR/DR scans with a DMI request scoreboard,
// plus hand-written reset, TMS-escape, pause and mid-scan reset sequences.
module tb_jtag_tap;
  import jtag_pkg::*;

`ifdef JTAG_DTMCS_WRITE_EN
  localparam int WR_EN = 1;
`else
  localparam int WR_EN = 0;
`endif

  localparam logic [31:0] IDCODE_VAL = 32'h1e200a6f;
  localparam logic [31:0] DTMCS_VAL  = 32'h00005071;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        tap_req;
  logic [39:0] tap_data;
  logic [39:0] dm_resp = '0;
  logic [31:0] idcode = IDCODE_VAL;
  logic [31:0] dtmcs = DTMCS_VAL;
  logic        dmireset;
  logic        dmihardreset;

  int n_checks = 0;
  int n_errors = 0;
  int n_rst_pulses = 0;
  int n_hard_pulses = 0;
  logic [39:0] req_q[$];

  typedef struct {
    string       name;
    logic [4:0]  ir;
    logic [39:0] resp;
    logic [39:0] tdi_v;
    int          len;
    int          pause_at;
    logic [39:0] exp_tdo;
    bit          exp_req;
    int          exp_rst;
    int          exp_hard;
  } vec_t;

  vec_t vecs[$];

  jtag_tap u_dut (
    .jtag_tck_i     (tck),
    .jtag_trst_i    (trst),
    .jtag_tms_i     (tms),
    .jtag_tdi_i     (tdi),
    .jtag_tdo_o     (tdo),
    .tap_req_o      (tap_req),
    .tap_data_o     (tap_data),
    .dm_resp_i      (dm_resp),
    .idcode_i       (idcode),
    .dtmcs_i        (dtmcs),
    .dmireset_o     (dmireset),
    .dmihardreset_o (dmihardreset)
  );

  always #5 tck = ~tck;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // One TCK cycle; outputs are observed 1ns after the rising edge and DMI pulses scored.
  task automatic step(input logic t_ms, input logic t_di);
    @(negedge tck);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    #1;
    if (tap_req === 1'b1) begin
      if (req_q.size() == 0) begin
        chk("unexpected_tap_req", 64'(tap_req), 64'(0));
      end else begin
        chk("tap_data_o", 64'(tap_data), 64'(req_q.pop_front()));
      end
    end
    if (dmireset === 1'b1) n_rst_pulses++;
    if (dmihardreset === 1'b1) n_hard_pulses++;
  endtask

  task automatic ir_scan(input logic [4:0] ir, output logic [4:0] cap);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cap[i] = tdo;
      step(i == 4, ir[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input logic [39:0] tv, input int n, input int pause_at,
                         output logic [39:0] tdo_v);
    tdo_v = '0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tdo_v[i] = tdo;
      step((i == n - 1) || (i == pause_at - 1), tv[i]);
      if ((i != n - 1) && (i == pause_at - 1)) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
      end
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic add_vec(input string name, input logic [4:0] ir, input logic [39:0] resp,
                         input logic [39:0] tv, input int len, input int pause_at,
                         input logic [39:0] exp_tdo, input bit exp_req,
                         input int exp_rst, input int exp_hard);
    vec_t v;
    v.name = name; v.ir = ir; v.resp = resp; v.tdi_v = tv; v.len = len;
    v.pause_at = pause_at; v.exp_tdo = exp_tdo; v.exp_req = exp_req;
    v.exp_rst = exp_rst; v.exp_hard = exp_hard;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ir_cap;
    logic [39:0] tdo_v;
    logic [39:0] mask;
    logic [39:0] bypass_pat;

    bypass_pat = 40'hC3_5A5A_0F0F;
    add_vec("idcode",      5'h01, '0, '0, 32, 0, 40'(IDCODE_VAL), 1'b0, 0, 0);
    add_vec("idcode_pause",5'h01, '0, 40'hFF_FFFF_FFFF, 32, 10, 40'(IDCODE_VAL), 1'b0, 0, 0);
    add_vec("dtmcs_read",  5'h10, '0, '0, 32, 0, 40'(DTMCS_VAL), 1'b0, 0, 0);
    add_vec("dmi_write",   5'h11, 40'h12_3456_789B, {6'h10, 32'h0000_0001, 2'b10}, 40, 0,
            40'h12_3456_789B, 1'b1, 0, 0);
    add_vec("bypass",      5'h1f, '0, 40'hD, 4, 0, 40'hA, 1'b0, 0, 0);
    add_vec("unknown_ir",  5'h07, 40'hAA_AAAA_AAAA, bypass_pat, 40, 0, bypass_pat << 1, 1'b0, 0, 0);
    add_vec("dmi_busy",    5'h11, 40'h3C_DEAD_BEEF, {6'h3f, 32'hcafe_f00d, 2'b01}, 40, 17,
            40'h3C_DEAD_BEEF, 1'b1, 0, 0);
    add_vec("dtmcs_reset", 5'h10, '0, 40'h0001_0000, 32, 0, 40'(DTMCS_VAL), 1'b0, WR_EN, 0);
    add_vec("dtmcs_hard",  5'h10, '0, 40'h0002_0000, 32, 0, 40'(DTMCS_VAL), 1'b0, 0, WR_EN);

    // Reset state.
    trst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_state", 64'(u_dut.w_state), 64'(TAP_TLR));
    chk("rst_tdo", 64'(tdo), 64'(0));
    chk("rst_tap_req", 64'(tap_req), 64'(0));
    chk("rst_tap_data", 64'(tap_data), 64'(0));
    chk("rst_dmireset", 64'(dmireset), 64'(0));
    chk("rst_dmihardreset", 64'(dmihardreset), 64'(0));
    trst = 1'b0;

    // Five TMS=1 cycles reach TLR from any state; TLR leaves IR at IDCODE.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    chk("tms5_state", 64'(u_dut.w_state), 64'(TAP_TLR));
    step(1'b0, 1'b0);
    dr_scan('0, 32, 0, tdo_v);
    chk("tlr_idcode_tdo", 64'(tdo_v[31:0]), 64'(IDCODE_VAL));

    // Table of IR+DR scans.
    foreach (vecs[v]) begin
      dm_resp = vecs[v].resp;
      ir_scan(vecs[v].ir, ir_cap);
      chk({vecs[v].name, "_ir_capture"}, 64'(ir_cap), 64'(5'b00001));
      if (vecs[v].exp_req) req_q.push_back(vecs[v].tdi_v);
      n_rst_pulses = 0;
      n_hard_pulses = 0;
      dr_scan(vecs[v].tdi_v, vecs[v].len, vecs[v].pause_at, tdo_v);
      mask = (vecs[v].len >= 40) ? '1 : ((40'd1 << vecs[v].len) - 40'd1);
      chk({vecs[v].name, "_tdo"}, 64'(tdo_v & mask), 64'(vecs[v].exp_tdo & mask));
      chk({vecs[v].name, "_req_pending"}, 64'(req_q.size()), 64'(0));
      chk({vecs[v].name, "_dmireset_cycles"}, 64'(n_rst_pulses), 64'(vecs[v].exp_rst));
      chk({vecs[v].name, "_dmihardreset_cycles"}, 64'(n_hard_pulses), 64'(vecs[v].exp_hard));
    end

    // Reset in the middle of a DMI shift: back to TLR, IDCODE selected, no request.
    dm_resp = 40'h55_0000_0003;
    ir_scan(5'h11, ir_cap);
    chk("midrst_ir_capture", 64'(ir_cap), 64'(5'b00001));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom_range(0, 1)));
    trst = 1'b1;
    step(1'b0, 1'b0);
    chk("midrst_state", 64'(u_dut.w_state), 64'(TAP_TLR));
    chk("midrst_tap_data", 64'(tap_data), 64'(0));
    chk("midrst_tdo", 64'(tdo), 64'(0));
    trst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("midrst_rti", 64'(u_dut.w_state), 64'(TAP_RTI));
    dr_scan('0, 32, 0, tdo_v);
    chk("midrst_idcode_tdo", 64'(tdo_v[31:0]), 64'(IDCODE_VAL));
    chk("final_req_pending", 64'(req_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
